// File: rtl/hwpe_stream_sink_monitor_if.sv
// Stream interface: data/strb/valid from the source, ready back from the sink.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source  (output valid, data, strb, input ready);
    modport sink    (input valid, data, strb, output ready);
    modport monitor (input valid, ready, data, strb);
endinterface

// File: rtl/hwpe_stream_sink_monitor.sv
// Stream sink with LFSR-driven backpressure, beat counting, a 32-bit MISR
// over the strobe-masked data, and a sticky valid/ready protocol checker.
module hwpe_stream_sink_monitor #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter logic [7:0]  STALL_THRESH = 8'd0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                 clk_i,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] len_i,
    input  logic                 force_ready_i,
    hwpe_stream_intf_stream.sink data_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] beat_cnt_o,
    output logic [31:0]          signature_o,
    output logic                 proto_err_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned NSLICE     = (DATA_WIDTH + 31) / 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q;
    logic [CNT_WIDTH-1:0]   len_q;
    logic [CNT_WIDTH-1:0]   beat_cnt_q;
    logic [CNT_WIDTH-1:0]   beat_cnt_d;
    logic [31:0]            sig_q;
    logic [31:0]            sig_d;
    logic                   perr_q;
    logic [15:0]            lfsr_q;
    logic [15:0]            lfsr_d;
    logic                   hold_q;
    logic [DATA_WIDTH-1:0]  hold_data_q;
    logic [STRB_WIDTH-1:0]  hold_strb_q;

    logic                   run;
    logic                   stall_rnd;
    logic                   ready;
    logic                   accept;
    logic                   proto_viol;

    // Zero the bytes whose strobe is low, then XOR-fold into 32 bits
    // (the last slice is zero-padded when DATA_WIDTH is not a multiple of 32).
    function automatic logic [31:0] fold_beat(input logic [DATA_WIDTH-1:0] data,
                                              input logic [STRB_WIDTH-1:0] strb);
        logic [NSLICE*32-1:0] padded;
        logic [31:0]          acc;
        padded = '0;
        for (int k = 0; k < int'(STRB_WIDTH); k++) begin
            padded[k*8 +: 8] = strb[k] ? data[k*8 +: 8] : 8'h00;
        end
        acc = '0;
        for (int s = 0; s < int'(NSLICE); s++) begin
            acc = acc ^ padded[s*32 +: 32];
        end
        return acc;
    endfunction

    // One MISR step with taps 31, 21, 1, 0.
    function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] f);
        return {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ f;
    endfunction

    // One Fibonacci LFSR step with taps 15, 13, 12, 10.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    assign run       = (state_q == RUN);
    // Borrow-free unsigned compare: stall when the low LFSR byte is below the threshold.
    assign stall_rnd = ({1'b0, lfsr_q[7:0]} < {1'b0, STALL_THRESH});

    // Ready is withheld during restart/clear cycles and once the length is met
    // (the len==0 case), so no beat can slip in while the run is being re-armed.
    assign ready = enable_i & run & ~start_i & ~clear_i
                 & (beat_cnt_q != len_q)
                 & (force_ready_i | ~stall_rnd);

    assign data_i.ready = ready;
    assign accept       = data_i.valid & ready;

    assign beat_cnt_d = beat_cnt_q + 1'b1;
    assign sig_d      = misr_step(sig_q, fold_beat(data_i.data, data_i.strb));
    assign lfsr_d     = lfsr_step(lfsr_q);

    // A stalled offer from the previous checked cycle must be repeated unchanged.
    assign proto_viol = hold_q & (~data_i.valid
                                  | (data_i.data != hold_data_q)
                                  | (data_i.strb != hold_strb_q));

    // Control FSM, counters, LFSR, signature and sticky error flag.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q    <= IDLE;
            len_q      <= '0;
            beat_cnt_q <= '0;
            sig_q      <= '0;
            perr_q     <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            hold_q     <= 1'b0;
        end else if (enable_i) begin
            if (start_i) begin
                state_q    <= RUN;
                len_q      <= len_i;
                beat_cnt_q <= '0;
                sig_q      <= '0;
                perr_q     <= 1'b0;
                lfsr_q     <= LFSR_SEED;
                hold_q     <= 1'b0;
            end else if (state_q == RUN) begin
                lfsr_q <= lfsr_d;
                hold_q <= data_i.valid & ~ready;
                if (proto_viol) begin
                    perr_q <= 1'b1;
                end
                if (beat_cnt_q == len_q) begin
                    state_q <= DONE;
                end else if (accept) begin
                    beat_cnt_q <= beat_cnt_d;
                    sig_q      <= sig_d;
                    if (beat_cnt_d == len_q) begin
                        state_q <= DONE;
                    end
                end
            end
        end
    end

    // Reference sample for the protocol check; only meaningful while hold_q is set,
    // and retained across disabled cycles.
    always_ff @(posedge clk_i) begin
        if (enable_i && run) begin
            hold_data_q <= data_i.data;
            hold_strb_q <= data_i.strb;
        end
    end

    assign busy_o      = run;
    assign done_o      = (state_q == DONE);
    assign beat_cnt_o  = beat_cnt_q;
    assign signature_o = sig_q;
    assign proto_err_o = perr_q;

endmodule

// File: tb/tb_hwpe_stream_sink_monitor.sv
// Bench for hwpe_stream_sink_monitor: vector table, directed corner cases,
// and randomized runs against a spec-level model.
module tb_hwpe_stream_sink_monitor;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          clear, enable, start, force_ready;
    logic [CW-1:0] len_r;
    logic          busy, done, perr;
    logic [CW-1:0] cnt;
    logic [31:0]   sig;

    always #5 clk = ~clk;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) s_if ();

    hwpe_stream_sink_monitor #(
        .DATA_WIDTH   (DW),
        .CNT_WIDTH    (CW),
        .STALL_THRESH (8'd128),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk_i         (clk),
        .clear_i       (clear),
        .enable_i      (enable),
        .start_i       (start),
        .len_i         (len_r),
        .force_ready_i (force_ready),
        .data_i        (s_if.sink),
        .busy_o        (busy),
        .done_o        (done),
        .beat_cnt_o    (cnt),
        .signature_o   (sig),
        .proto_err_o   (perr)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          len;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  s0;
        logic [3:0]  s1;
        logic [31:0] mid;
        logic [31:0] fin;
    } vec_t;

    vec_t        tbl [8];
    logic [15:0] lseq [0:8191];
    logic [31:0] arr [1000];
    logic [31:0] bvals [6];
    logic [31:0] exp_sig, sig_run1;
    int          idx, low, runcyc, n, acc, l, cyc;
    bit          in_run, stalled, found, exp_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [CW-1:0] l_in);
        start = 1'b1;
        len_r = l_in;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [31:0] mask_beat(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            if (s[k]) m[8*k +: 8] = d[8*k +: 8];
        end
        return m;
    endfunction

    function automatic logic [31:0] misr(input logic [31:0] sg, input logic [31:0] f);
        return ((sg << 1) | {31'b0, ^(sg & 32'h8020_0003)}) ^ f;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v << 1) | {15'b0, ^(v & 16'hB400)};
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        lseq[0] = 16'hACE1;
        for (int i = 1; i < 8192; i++) lseq[i] = lfsr_next(lseq[i-1]);

        tbl[0] = '{2, 32'h0000_0001, 32'h0000_0001, 4'hF, 4'hF, 32'h0000_0001, 32'h0000_0002};
        tbl[1] = '{1, 32'hFFFF_FFFF, 32'h0,         4'h5, 4'h0, 32'h00FF_00FF, 32'h00FF_00FF};
        tbl[2] = '{1, 32'hFFFF_FFFF, 32'h0,         4'hA, 4'h0, 32'hFF00_FF00, 32'hFF00_FF00};
        tbl[3] = '{1, 32'h1234_5678, 32'h0,         4'h8, 4'h0, 32'h1200_0000, 32'h1200_0000};
        tbl[4] = '{1, 32'hA5A5_A5A5, 32'h0,         4'h0, 4'h0, 32'h0000_0000, 32'h0000_0000};
        tbl[5] = '{2, 32'h8000_0000, 32'h0,         4'hF, 4'hF, 32'h8000_0000, 32'h0000_0001};
        tbl[6] = '{2, 32'h0020_0000, 32'h0,         4'hF, 4'hF, 32'h0020_0000, 32'h0040_0001};
        tbl[7] = '{2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'hF, 4'hF, 32'hDEAD_BEEF, 32'h63F6_C331};

        clear = 1'b1; enable = 1'b1; start = 1'b0; force_ready = 1'b0; len_r = '0;
        s_if.valid = 1'b0; s_if.data = '0; s_if.strb = '0;
        tick(); tick();
        clear = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_sig", sig, 0);
        chk("rst_perr", perr, 0);
        chk("rst_ready", s_if.ready, 0);
        tick();

        // Vector table: one- and two-beat runs with ready forced.
        force_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            s_if.valid = 1'b0;
            start_run(tbl[v].len[CW-1:0]);
            s_if.valid = 1'b1; s_if.data = tbl[v].d0; s_if.strb = tbl[v].s0;
            #1;
            chk($sformatf("tbl%0d_ready", v), s_if.ready, 1);
            tick();
            chk($sformatf("tbl%0d_mid", v), sig, tbl[v].mid);
            if (tbl[v].len == 2) begin
                s_if.data = tbl[v].d1; s_if.strb = tbl[v].s1;
                #1;
                chk($sformatf("tbl%0d_ready2", v), s_if.ready, 1);
                tick();
            end
            s_if.valid = 1'b0;
            chk($sformatf("tbl%0d_done", v), done, 1);
            chk($sformatf("tbl%0d_busy", v), busy, 0);
            chk($sformatf("tbl%0d_cnt", v), cnt, tbl[v].len[31:0]);
            chk($sformatf("tbl%0d_sig", v), sig, tbl[v].fin);
        end

        // Zero-length run: done after one cycle, ready never raised.
        s_if.valid = 1'b1; s_if.data = 32'h1111_1111; s_if.strb = 4'hF;
        start_run(0);
        chk("len0_busy", busy, 1);
        chk("len0_ready", s_if.ready, 0);
        tick();
        chk("len0_done", done, 1);
        chk("len0_cnt", cnt, 0);
        chk("len0_sig", sig, 0);
        chk("len0_ready_after", s_if.ready, 0);

        // Protocol violations: data change (mode 0) or valid drop (mode 1) during a stall.
        for (int mode = 0; mode < 2; mode++) begin
            force_ready = 1'b0;
            s_if.valid = 1'b1; s_if.data = 32'hA5A5_A5A5; s_if.strb = 4'hF;
            start_run(200);
            found = 1'b0;
            for (int c = 0; c < 100 && !found; c++) begin
                #1;
                if (!s_if.ready) found = 1'b1;
                else tick();
            end
            chk($sformatf("perr%0d_stall_seen", mode), found, 1);
            tick();
            if (mode == 0) s_if.data = 32'h5A5A_5A5A;
            else s_if.valid = 1'b0;
            chk($sformatf("perr%0d_before", mode), perr, 0);
            tick();
            chk($sformatf("perr%0d_set", mode), perr, 1);
            s_if.valid = 1'b1;
            force_ready = 1'b1;
            for (int c = 0; c < 400 && !done; c++) tick();
            chk($sformatf("perr%0d_done", mode), done, 1);
            chk($sformatf("perr%0d_sticky", mode), perr, 1);
            start_run(1);
            chk($sformatf("perr%0d_cleared", mode), perr, 0);
            tick();
        end

        // Long run with ~50% stalls, then the same data with ready forced.
        for (int i = 0; i < 1000; i++) arr[i] = $urandom;
        exp_sig = '0;
        for (int i = 0; i < 1000; i++) exp_sig = misr(exp_sig, arr[i]);
        for (int pass = 0; pass < 2; pass++) begin
            force_ready = (pass == 1);
            s_if.valid = 1'b0;
            start_run(1000);
            idx = 0; low = 0; runcyc = 0;
            for (int c = 0; c < 5000 && !done; c++) begin
                s_if.valid = 1'b1; s_if.data = arr[idx % 1000]; s_if.strb = 4'hF;
                #1;
                runcyc++;
                if (!s_if.ready) low++;
                else idx++;
                tick();
            end
            s_if.valid = 1'b0;
            chk($sformatf("long%0d_done", pass), done, 1);
            chk($sformatf("long%0d_cnt", pass), cnt, 1000);
            chk($sformatf("long%0d_beats", pass), idx, 1000);
            chk($sformatf("long%0d_sig", pass), sig, exp_sig);
            chk($sformatf("long%0d_perr", pass), perr, 0);
            if (pass == 0) begin
                sig_run1 = sig;
                chk("long0_stall_ratio",
                    ((low * 100 >= 40 * runcyc) && (low * 100 <= 60 * runcyc)), 1);
            end else begin
                chk("long1_same_sig", sig, sig_run1);
                chk("long1_no_stall", low, 0);
            end
        end

        // Clear in the middle of a run, with start asserted alongside.
        force_ready = 1'b1;
        s_if.valid = 1'b0;
        start_run(10);
        s_if.valid = 1'b1; s_if.data = 32'h0F0F_0F0F; s_if.strb = 4'hF;
        for (int c = 0; c < 5; c++) tick();
        chk("clr_cnt5", cnt, 5);
        clear = 1'b1; start = 1'b1;
        tick();
        clear = 1'b0; start = 1'b0;
        #1;
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        chk("clr_cnt", cnt, 0);
        chk("clr_sig", sig, 0);
        chk("clr_perr", perr, 0);
        chk("clr_ready", s_if.ready, 0);
        tick();

        // Restart while running: ready low in the restart cycle, counters re-armed.
        start_run(6);
        tick(); tick();
        chk("rst_run_cnt2", cnt, 2);
        start = 1'b1; len_r = 6;
        #1;
        chk("restart_ready", s_if.ready, 0);
        tick();
        start = 1'b0;
        chk("restart_cnt", cnt, 0);
        chk("restart_sig", sig, 0);
        chk("restart_busy", busy, 1);

        // Enable window of three cycles inside the run.
        for (int i = 0; i < 6; i++) bvals[i] = 32'h1000_0000 * (i + 1) + i;
        exp_sig = '0;
        for (int i = 0; i < 6; i++) exp_sig = misr(exp_sig, bvals[i]);
        idx = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            enable = !(idx == 2 && c >= 2 && c < 5);
            s_if.valid = 1'b1; s_if.data = bvals[idx]; s_if.strb = 4'hF;
            #1;
            if (!enable) chk("dis_ready", s_if.ready, 0);
            if (s_if.ready) idx++;
            tick();
            if (!enable) chk("dis_cnt_hold", cnt, 2);
        end
        enable = 1'b1;
        s_if.valid = 1'b0;
        chk("en_done", done, 1);
        chk("en_cnt", cnt, 6);
        chk("en_sig", sig, exp_sig);

        // Randomized runs against the model.
        for (int r = 0; r < 8; r++) begin
            l = $urandom_range(1, 60);
            force_ready = ($urandom_range(0, 3) == 0);
            enable = 1'b1;
            s_if.valid = 1'b0;
            start = 1'b1; len_r = l[CW-1:0];
            #1;
            chk("rnd_ready_start", s_if.ready, 0);
            tick();
            start = 1'b0;
            in_run = 1'b1; n = 0; acc = 0; stalled = 1'b0; exp_sig = '0; cyc = 0;
            while (in_run && cyc < 3000) begin
                enable = ($urandom_range(0, 9) != 0);
                if (!stalled) begin
                    s_if.valid = ($urandom_range(0, 3) != 0);
                    s_if.data  = $urandom;
                    s_if.strb  = 4'($urandom);
                end
                #1;
                exp_rdy = enable && (acc != l) && (force_ready || lseq[n][7:0] >= 8'd128);
                chk("rnd_ready", s_if.ready, exp_rdy);
                stalled = s_if.valid && !exp_rdy;
                if (s_if.valid && exp_rdy) begin
                    exp_sig = misr(exp_sig, mask_beat(s_if.data, s_if.strb));
                    acc++;
                end
                if (enable) n++;
                if (acc == l) in_run = 1'b0;
                tick();
                cyc++;
            end
            enable = 1'b1;
            s_if.valid = 1'b0;
            chk("rnd_done", done, 1);
            chk("rnd_busy", busy, 0);
            chk("rnd_cnt", cnt, l);
            chk("rnd_sig", sig, exp_sig);
            chk("rnd_perr", perr, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
